// File: rtl/key_event_scan.sv
// key_event_scan: debounces KEY_NUM raw key inputs, exports the debounced
// level vector with a legacy change pulse, and classifies key activity into
// PRESS / RELEASE / LONG / REPEAT events delivered one at a time over a
// valid/ready handshake.
//
// Per-channel hold FSM:
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   H_IDLE   | key released (or just pressed), hold counter at zero
//   H_LONG   | key held, counting towards the LONG event
//   H_REPEAT | LONG already emitted, counting REPEAT periods
//   H_SAT    | LONG already emitted, repeats disabled, counter frozen
module key_event_scan #(
  parameter int KEY_NUM      = 4,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int LONG_CYC     = 50000000,
  parameter int REPEAT_CYC   = 10000000,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] key_data,
  output logic               key_chg,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [3:0]         evt_key,
  output logic [1:0]         evt_type,
  output logic               evt_ovf,
  input  logic               ovf_clr
);

  localparam logic REL_LVL = ACTIVE_LOW;
  localparam logic PRS_LVL = !ACTIVE_LOW;

  localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int LONG_W = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
  localparam int REP_W  = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  localparam int HOLD_W = (LONG_W > REP_W) ? LONG_W : REP_W;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYC - 1);

  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_RELEASE = 2'd1;
  localparam logic [1:0] EVT_LONG    = 2'd2;
  localparam logic [1:0] EVT_REPEAT  = 2'd3;

  typedef enum logic [1:0] {
    H_IDLE   = 2'd0,
    H_LONG   = 2'd1,
    H_REPEAT = 2'd2,
    H_SAT    = 2'd3
  } hold_state_t;

  logic [KEY_NUM-1:0] sync1;
  logic [KEY_NUM-1:0] sync2;
  logic [DB_W-1:0]    db_cnt [KEY_NUM];
  logic [KEY_NUM-1:0] accept;
  logic [KEY_NUM-1:0] key_data_d;
  logic [KEY_NUM-1:0] pressed;

  hold_state_t        hold_st      [KEY_NUM];
  hold_state_t        hold_nxt     [KEY_NUM];
  logic [HOLD_W-1:0]  hold_cnt     [KEY_NUM];
  logic [HOLD_W-1:0]  hold_cnt_nxt [KEY_NUM];
  logic [KEY_NUM-1:0] hold_evt;
  logic [1:0]         hold_type    [KEY_NUM];

  logic [KEY_NUM-1:0] new_evt;
  logic [1:0]         new_type  [KEY_NUM];
  logic [KEY_NUM-1:0] slot_vld;
  logic [1:0]         slot_type [KEY_NUM];

  logic               load;
  logic               sel_found;
  logic [3:0]         sel_idx;
  logic [1:0]         sel_type;
  logic [KEY_NUM-1:0] take_mask;
  logic               ovf_hit;

  assign pressed = ACTIVE_LOW ? ~key_data : key_data;
  assign load    = !evt_valid || evt_ready;

  // Two-flop synchroniser; only sync2 feeds the debouncers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= {KEY_NUM{REL_LVL}};
      sync2 <= {KEY_NUM{REL_LVL}};
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  // A channel accepts its synced level after DEBOUNCE_CYC mismatching cycles.
  always_comb begin
    accept = '0;
    for (int i = 0; i < KEY_NUM; i++) begin
      accept[i] = (sync2[i] != key_data[i]) && (db_cnt[i] == DB_LAST);
    end
  end

  // Debounce counters and the debounced level register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_data <= {KEY_NUM{REL_LVL}};
      for (int i = 0; i < KEY_NUM; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < KEY_NUM; i++) begin
        if (sync2[i] == key_data[i]) begin
          db_cnt[i] <= '0;
        end else if (accept[i]) begin
          db_cnt[i]   <= '0;
          key_data[i] <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Legacy change pulse: one cycle after any debounced bit moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_data_d <= {KEY_NUM{REL_LVL}};
      key_chg    <= 1'b0;
    end else begin
      key_data_d <= key_data;
      key_chg    <= |(key_data ^ key_data_d);
    end
  end

  // Hold FSM state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KEY_NUM; i++) begin
        hold_st[i]  <= H_IDLE;
        hold_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < KEY_NUM; i++) begin
        hold_st[i]  <= hold_nxt[i];
        hold_cnt[i] <= hold_cnt_nxt[i];
      end
    end
  end

  // Hold FSM next state: LONG after LONG_CYC held cycles, then periodic REPEAT.
  always_comb begin
    for (int i = 0; i < KEY_NUM; i++) begin
      hold_nxt[i]     = hold_st[i];
      hold_cnt_nxt[i] = hold_cnt[i];
      hold_evt[i]     = 1'b0;
      hold_type[i]    = EVT_LONG;
      if (!pressed[i]) begin
        hold_nxt[i]     = H_IDLE;
        hold_cnt_nxt[i] = '0;
      end else begin
        case (hold_st[i])
          H_IDLE, H_LONG: begin
            if (hold_cnt[i] == LONG_LAST) begin
              hold_evt[i]     = 1'b1;
              hold_type[i]    = EVT_LONG;
              hold_cnt_nxt[i] = '0;
              hold_nxt[i]     = REPEAT_EN ? H_REPEAT : H_SAT;
            end else begin
              hold_cnt_nxt[i] = hold_cnt[i] + HOLD_W'(1);
              hold_nxt[i]     = H_LONG;
            end
          end
          H_REPEAT: begin
            if (hold_cnt[i] == REP_LAST) begin
              hold_evt[i]     = 1'b1;
              hold_type[i]    = EVT_REPEAT;
              hold_cnt_nxt[i] = '0;
            end else begin
              hold_cnt_nxt[i] = hold_cnt[i] + HOLD_W'(1);
            end
          end
          H_SAT: begin
            hold_cnt_nxt[i] = hold_cnt[i];
          end
          default: begin
            hold_nxt[i]     = H_IDLE;
            hold_cnt_nxt[i] = '0;
          end
        endcase
      end
    end
  end

  // Per-channel event source; a debounced transition wins over a hold event
  // so a release coinciding with LONG/REPEAT is never lost.
  always_comb begin
    for (int i = 0; i < KEY_NUM; i++) begin
      new_evt[i]  = accept[i] | hold_evt[i];
      new_type[i] = hold_type[i];
      if (accept[i]) begin
        new_type[i] = (sync2[i] == PRS_LVL) ? EVT_PRESS : EVT_RELEASE;
      end
    end
  end

  // Lowest-index occupied slot; scanning downwards leaves the lowest selected.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 4'd0;
    sel_type  = EVT_PRESS;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (slot_vld[i]) begin
        sel_found = 1'b1;
        sel_idx   = 4'(i);
        sel_type  = slot_type[i];
      end
    end
  end

  // Slot being unloaded this cycle, and overflow into a slot that stays busy.
  always_comb begin
    take_mask = '0;
    for (int i = 0; i < KEY_NUM; i++) begin
      take_mask[i] = load && sel_found && (sel_idx == 4'(i));
    end
    ovf_hit = |(new_evt & slot_vld & ~take_mask);
  end

  // Pending slots: a new event always lands, overwriting any stale type.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld <= '0;
      for (int i = 0; i < KEY_NUM; i++) begin
        slot_type[i] <= EVT_PRESS;
      end
    end else begin
      for (int i = 0; i < KEY_NUM; i++) begin
        if (new_evt[i]) begin
          slot_vld[i]  <= 1'b1;
          slot_type[i] <= new_type[i];
        end else if (take_mask[i]) begin
          slot_vld[i] <= 1'b0;
        end
      end
    end
  end

  // Output register: reloads whenever empty or handshaking, holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_key   <= 4'd0;
      evt_type  <= EVT_PRESS;
    end else if (load) begin
      evt_valid <= sel_found;
      if (sel_found) begin
        evt_key  <= sel_idx;
        evt_type <= sel_type;
      end
    end
  end

  // Sticky overflow flag; clear beats a simultaneous set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_ovf <= 1'b0;
    end else if (ovf_clr) begin
      evt_ovf <= 1'b0;
    end else if (ovf_hit) begin
      evt_ovf <= 1'b1;
    end
  end

endmodule

// File: doc/key_event_scan.md
Name: key_event_scan

Overview:
- Parametrised successor to the fixed 4-key debounce/change-detect block.
- Debounces KEY_NUM asynchronous key inputs and exports the debounced level vector plus a legacy one-cycle change pulse.
- Classifies each key's activity into PRESS / RELEASE / LONG / REPEAT events and delivers them one at a time over a valid/ready handshake to the downstream frame builder (RS485 TX path).

Parameters:
- KEY_NUM, 4, number of key channels (1..16)
- ACTIVE_LOW, 1, 1 = key pressed when input is 0
- DEBOUNCE_CYC, 1000000, cycles a new level must hold before acceptance (20 ms at 50 MHz)
- LONG_CYC, 50000000, cycles pressed (after debounce) before a LONG event (1 s)
- REPEAT_CYC, 10000000, period of REPEAT events after LONG (200 ms)
- REPEAT_EN, 1, 1 = generate REPEAT events; 0 = LONG only

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous reset, active-low
- key  in  KEY_NUM  raw key inputs, asynchronous
- key_data  out  KEY_NUM  debounced levels, raw polarity
- key_chg  out  1  one-cycle pulse, any key_data bit changed
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready
- evt_key  out  4  channel index of the event
- evt_type  out  2  0=PRESS, 1=RELEASE, 2=LONG, 3=REPEAT
- evt_ovf  out  1  sticky: a pending event was overwritten
- ovf_clr  in  1  synchronous clear of evt_ovf

Behaviour:
- Design is governed by clk; rst_n is asynchronous, active-low.
- Reset values:
  - key_data = all 1s if ACTIVE_LOW, else all 0s.
  - key_chg, evt_valid, evt_ovf = 0; evt_key, evt_type = 0.
  - All counters, sync flops and pending slots are cleared; sync flops take the released level.
- Input synchronisation: 2-flop synchroniser per channel; sync flops are never used by other logic.
- Debounce, per channel:
  - Counter clears whenever the synced level equals key_data[i].
  - Otherwise the counter increments.
  - At count DEBOUNCE_CYC-1, key_data[i] takes the synced level and the counter clears.
  - A glitch shorter than DEBOUNCE_CYC never changes key_data.
- key_chg: registered, high the cycle after any key_data bit changes.
- PRESS / RELEASE: emitted in the same cycle key_data[i] moves to the pressed / released level.
- Hold counter, per channel:
  - Runs while the key is pressed; clears on release.
  - At LONG_CYC-1: emits LONG.
  - If REPEAT_EN: then emits REPEAT every REPEAT_CYC cycles while held.
  - Counter saturates without wrapping when REPEAT_EN=0.
  - A RELEASE still follows a LONG or REPEAT.
- Pending slots: one per channel (valid bit + type).
  - A new event into an occupied slot overwrites the type and sets evt_ovf.
  - If the slot is being unloaded in the same cycle, the new event fills it with no overflow.
- Output register:
  - Loads when !evt_valid or (evt_valid && evt_ready).
  - Source is the lowest-index occupied slot, which is freed in the same cycle.
  - If no slot is occupied, evt_valid drops to 0 after the handshake.
  - evt_key and evt_type are stable while evt_valid && !evt_ready.
  - Throughput: 1 event/cycle when ready is held high.
  - Latency: debounced transition to evt_valid is 1 cycle when the output is free.
- evt_ovf: ovf_clr has priority over a new set in the same cycle.
- Counter widths are derived with $clog2 of the respective cycle parameter; evt_key is zero-extended for KEY_NUM < 16.

Test Plan (sim parameters: KEY_NUM=4, DEBOUNCE_CYC=8, LONG_CYC=40, REPEAT_CYC=16, REPEAT_EN=1, ACTIVE_LOW=1; evt_ready=1 unless stated):
- key[0] low for 5 cycles then high -> key_data stays 4'hF, no key_chg, no event.
- key[1] low for 20 cycles then high -> key_data[1]=0 about 10 cycles after the edge, key_chg pulses once, event (key=1, type=0); after release, event (key=1, type=1).
- key[2] held low 80 cycles -> sequence PRESS, then LONG about 40 cycles later, then REPEAT at +16 and +32, then RELEASE after the key goes high.
- key[0] and key[3] pressed in the same cycle -> two consecutive events (key=0, PRESS) then (key=3, PRESS), one cycle apart.
- evt_ready=0 while key[1] is pressed and released -> evt_valid holds PRESS; the RELEASE overwrites nothing (the slot was freed on load) and is held pending. A further press on key[1] overwrites the pending slot and sets evt_ovf=1; ovf_clr then returns evt_ovf to 0.
- Assert rst_n mid-debounce and mid-hold -> all outputs are at reset values immediately; after release, no spurious events until key activity reaches the full debounce period.
